pipe_param_ex: RTL and testbench
================================

PIPE_PARAM_EX -- requirements
Module: pipe_param_ex

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>=8).
REQ-002 SHALL have parameter AW, default 5, destination register number width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; clrn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: id_valid, id_wreg, id_m2reg, id_wmem, id_mul  in  1 each  ID-stage valid, register write, load, store, multiply select.
REQ-005 SHALL have ports: id_aluc  in  4  ALU op; id_sel_a, id_sel_b  in  2 each  operand source selects; id_wn  in  AW  destination register.
REQ-006 SHALL have ports: id_qa, id_qb, id_imm, mem_fwd, wb_fwd  in  WIDTH each  register operands, shift-amount/immediate, MEM forward, WB forward.
REQ-007 SHALL have ports: flush  in  1  discard EX contents; mem_stall  in  1  downstream hold.
REQ-008 SHALL have ports: ex_stall  out  1  hold ID; ex_valid, ex_wreg, ex_m2reg, ex_wmem  out  1 each; ex_wn  out  AW; ex_result, ex_qb  out  WIDTH each.

Function
REQ-009 ID/EX register SHALL load all id_* inputs on a rising edge when ex_stall=0 and flush=0; it SHALL hold when ex_stall=1.
REQ-010 Operand select (a and b alike): 0 = qa (a) / qb (b), 1 = id_imm as latched, 2 = mem_fwd, 3 = wb_fwd; sampled combinationally in the EX cycle.
REQ-011 aluc encoding: x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui (b<<16), 0011 sll, 0111 srl, 1111 sra; shifts move b by a[log2(WIDTH)-1:0]; add/sub wrap modulo 2^WIDTH.
REQ-012 Non-multiply ops: ex_result SHALL be valid combinationally in the cycle after the ID/EX load (one-cycle EX latency).
REQ-013 ex_qb SHALL equal the latched id_qb, not forwarded.
REQ-014 Multiplier FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE with latched valid=1 and mul=1: operands a,b captured at the edge, counter cleared, next state BUSY.
REQ-016 BUSY: one radix-2 shift-add step per cycle; exactly WIDTH BUSY cycles; then DONE.
REQ-017 DONE: ex_result = low WIDTH bits of a*b (unsigned), held for one cycle unless mem_stall=1; then IDLE.
REQ-018 ex_stall = mem_stall OR (IDLE and latched valid and mul) OR BUSY; a multiply thus occupies EX for WIDTH+2 cycles.
REQ-019 While ex_stall is asserted by the multiplier, ex_valid, ex_wreg and ex_wmem SHALL be 0 (bubble downstream).
REQ-020 ex_valid = latched valid otherwise; ex_wreg, ex_wmem, ex_m2reg SHALL be 0 whenever ex_valid=0.
REQ-021 mem_stall=1 SHALL freeze the ID/EX register, FSM and multiplier datapath; outputs hold their values.
REQ-022 flush=1 SHALL, at the edge, load a bubble (all latched controls 0) and force FSM to IDLE, aborting any multiply; flush takes priority over mem_stall.
REQ-023 Product and counter SHALL be internal only; operand changes on mem_fwd/wb_fwd during BUSY SHALL NOT affect the result.

Reset
REQ-024 clrn=0 at a rising edge SHALL clear the ID/EX register, FSM to IDLE, counter and product to 0; priority clrn > flush > stall.
REQ-025 After reset all outputs SHALL be 0, including ex_stall (given mem_stall=0).
REQ-026 Reset during BUSY SHALL abort the multiply with no result produced.

Configuration
REQ-027 Macro PIPE_EX_MUL_EN defined: multiplier FSM and datapath per REQ-014..REQ-018 compiled in.
REQ-028 PIPE_EX_MUL_EN undefined: no multiplier logic; id_mul ignored (op executes per aluc); ex_stall = mem_stall.

Verification
REQ-029 Reset: clrn=0 one edge, then 1 -> all outputs 0, FSM IDLE, ex_stall=0.
REQ-030 Forward add: sel_a=2 mem_fwd=0x10, sel_b=1 imm=0x5, aluc=0000 -> ex_result=0x00000015, ex_valid=1 one cycle after load.
REQ-031 Shift: sel_a=1 imm=4, sel_b=0 qb=0x80000000, aluc=1111 -> ex_result=0xF8000000.
REQ-032 Multiply (MUL_EN, WIDTH=32): a=7, b=0xFFFFFFFF -> ex_stall=1 for 33 cycles, ex_wreg=0 throughout; 34th cycle ex_result=0xFFFFFFF9, ex_valid=1, ex_stall=0.
REQ-033 Flush in BUSY cycle 10 -> next cycle FSM IDLE, ex_valid=0, ex_stall=0, no product emitted.
REQ-034 mem_stall=1 for 3 cycles after an add loads -> ex_result, ex_wn and controls unchanged; the next ID instruction loads only after mem_stall falls.

Source files
------------

// File: rtl/pipe_param_ex.sv
// pipe_param_ex: EX stage of a 5-stage integer pipeline.
// Holds the ID/EX pipeline register, selects the ALU operands (register,
// immediate, MEM forward or WB forward) and computes a one-cycle ALU result.
// Optional macro PIPE_EX_MUL_EN adds an iterative radix-2 shift-add multiplier.
// The multiplier stalls ID for WIDTH+1 cycles and presents the low WIDTH bits
// of the unsigned product in its DONE cycle.
// Reset is synchronous and active-low (clrn). Priority is clrn > flush > stall.
module pipe_param_ex #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wmem,
  input  logic             id_mul,
  input  logic [3:0]       id_aluc,
  input  logic [1:0]       id_sel_a,
  input  logic [1:0]       id_sel_b,
  input  logic [AW-1:0]    id_wn,
  input  logic [WIDTH-1:0] id_qa,
  input  logic [WIDTH-1:0] id_qb,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             ex_stall,
  output logic             ex_valid,
  output logic             ex_wreg,
  output logic             ex_m2reg,
  output logic             ex_wmem,
  output logic [AW-1:0]    ex_wn,
  output logic [WIDTH-1:0] ex_result,
  output logic [WIDTH-1:0] ex_qb
);

  localparam int SHW = $clog2(WIDTH);

  // ID/EX pipeline register
  logic             r_valid, r_wreg, r_m2reg, r_wmem;
  logic [3:0]       r_aluc;
  logic [1:0]       r_sel_a, r_sel_b;
  logic [AW-1:0]    r_wn;
  logic [WIDTH-1:0] r_qa, r_qb, r_imm;

  logic [WIDTH-1:0] w_a, w_b, w_alu;
  logic             w_mul_stall;

  assign ex_stall = mem_stall | w_mul_stall;

  // ID/EX register: reset and flush load a bubble, any stall holds it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and the update order inside the block does not matter.
    if (!clrn || flush) begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_aluc  <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_wn    <= '0;
      r_qa    <= '0;
      r_qb    <= '0;
      r_imm   <= '0;
    end else if (!ex_stall) begin
      r_valid <= id_valid;
      r_wreg  <= id_wreg;
      r_m2reg <= id_m2reg;
      r_wmem  <= id_wmem;
      r_aluc  <= id_aluc;
      r_sel_a <= id_sel_a;
      r_sel_b <= id_sel_b;
      r_wn    <= id_wn;
      r_qa    <= id_qa;
      r_qb    <= id_qb;
      r_imm   <= id_imm;
    end
  end

  // Operand muxes: 0 register, 1 latched immediate, 2 MEM forward, 3 WB forward.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_a = r_qa;
    w_b = r_qb;
    case (r_sel_a)
      2'd0:    w_a = r_qa;
      2'd1:    w_a = r_imm;
      2'd2:    w_a = mem_fwd;
      default: w_a = wb_fwd;
    endcase
    case (r_sel_b)
      2'd0:    w_b = r_qb;
      2'd1:    w_b = r_imm;
      2'd2:    w_b = mem_fwd;
      default: w_b = wb_fwd;
    endcase
  end

  // ALU: aluc[2:0] picks the operation, aluc[3] only separates sra from srl.
  always_comb begin
    w_alu = w_a + w_b;
    case (r_aluc[2:0])
      3'b000:  w_alu = w_a + w_b;
      3'b100:  w_alu = w_a - w_b;
      3'b001:  w_alu = w_a & w_b;
      3'b101:  w_alu = w_a | w_b;
      3'b010:  w_alu = w_a ^ w_b;
      3'b110:  w_alu = w_b << 16;
      3'b011:  w_alu = w_b << w_a[SHW-1:0];
      default: w_alu = r_aluc[3] ? $unsigned($signed(w_b) >>> w_a[SHW-1:0])
                                 : (w_b >> w_a[SHW-1:0]);
    endcase
  end

`ifdef PIPE_EX_MUL_EN
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t       r_state, w_next;
  logic             r_mul;
  logic [WIDTH-1:0] r_ma, r_mb, r_prod;
  logic [CW-1:0]    r_cnt;

  // Multiply select travels with the rest of the ID/EX register.
  always_ff @(posedge clk) begin
    if (!clrn || flush) r_mul <= 1'b0;
    else if (!ex_stall) r_mul <= id_mul;
  end

  // Multiplier state register; flush aborts, mem_stall freezes.
  always_ff @(posedge clk) begin
    if (!clrn || flush)  r_state <= S_IDLE;
    else if (!mem_stall) r_state <= w_next;
  end

  // Next state: start on a latched multiply, WIDTH BUSY steps, one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_valid && r_mul) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == CNT_LAST) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shift-add datapath: operands are captured once, so forwards may change later.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (!flush && !mem_stall) begin
      if (r_state == S_IDLE && w_next == S_BUSY) begin
        r_ma   <= w_a;
        r_mb   <= w_b;
        r_prod <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
        if (r_mb[0]) r_prod <= r_prod + r_ma;
        r_ma  <= r_ma << 1;
        r_mb  <= r_mb >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_mul_stall = (r_state == S_IDLE && r_valid && r_mul) || (r_state == S_BUSY);
  assign ex_result   = (r_state == S_DONE) ? r_prod : w_alu;
`else
  logic w_unused_mul;

  // Without the multiplier id_mul has no effect and only mem_stall stalls.
  assign w_unused_mul = id_mul;
  assign w_mul_stall  = 1'b0;
  assign ex_result    = w_alu;
`endif

  assign ex_valid = r_valid & ~w_mul_stall;
  assign ex_wreg  = ex_valid & r_wreg;
  assign ex_m2reg = ex_valid & r_m2reg;
  assign ex_wmem  = ex_valid & r_wmem;
  assign ex_wn    = r_wn;
  assign ex_qb    = r_qb;

endmodule

// File: tb/tb_pipe_param_ex.sv
// Directed testbench for pipe_param_ex (WIDTH=32, AW=5).
// A vector table covers every ALU op and operand source. Hand-written
// sequences cover reset, flush, mem_stall and, with PIPE_EX_MUL_EN, multiply.
module tb_pipe_param_ex;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_valid, id_wreg, id_m2reg, id_wmem, id_mul;
  logic [3:0]  id_aluc;
  logic [1:0]  id_sel_a, id_sel_b;
  logic [4:0]  id_wn;
  logic [31:0] id_qa, id_qb, id_imm, mem_fwd, wb_fwd;
  logic        flush, mem_stall;
  logic        ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem;
  logic [4:0]  ex_wn;
  logic [31:0] ex_result, ex_qb;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [3:0]  aluc;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [31:0] mfwd;
    logic [31:0] wfwd;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  pipe_param_ex #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_mul(id_mul), .id_aluc(id_aluc),
    .id_sel_a(id_sel_a), .id_sel_b(id_sel_b), .id_wn(id_wn),
    .id_qa(id_qa), .id_qb(id_qb), .id_imm(id_imm),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .flush(flush), .mem_stall(mem_stall),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_wn(ex_wn),
    .ex_result(ex_result), .ex_qb(ex_qb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input vec_t v, input logic valid, input logic mul, input logic [4:0] wn);
    id_valid = valid;
    id_wreg  = v.wreg;
    id_m2reg = v.m2reg;
    id_wmem  = v.wmem;
    id_mul   = mul;
    id_aluc  = v.aluc;
    id_sel_a = v.sel_a;
    id_sel_b = v.sel_b;
    id_qa    = v.qa;
    id_qb    = v.qb;
    id_imm   = v.imm;
    id_wn    = wn;
  endtask

  task automatic drive_bubble();
    vec_t z;
    z = '{2'd0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    drive_id(z, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    vec_t mv, nv;

    //        sel_a sel_b aluc     qa            qb            imm           mfwd          wfwd          wr m2 wm exp
    vt[0]  = '{2'd2, 2'd1, 4'b0000, 32'h0,        32'h0,        32'h5,        32'h10,       32'h0,        1, 0, 0, 32'h00000015};
    vt[1]  = '{2'd1, 2'd0, 4'b1111, 32'h0,        32'h80000000, 32'h4,        32'h0,        32'h0,        1, 0, 0, 32'hF8000000};
    vt[2]  = '{2'd0, 2'd0, 4'b0100, 32'h5,        32'h7,        32'h0,        32'h0,        32'h0,        0, 0, 1, 32'hFFFFFFFE};
    vt[3]  = '{2'd0, 2'd0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'hF000F000};
    vt[4]  = '{2'd0, 2'd0, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'h0,        1, 0, 0, 32'hFFF0FFF0};
    vt[5]  = '{2'd0, 2'd0, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'h0,        1, 0, 0, 32'h0FF00FF0};
    vt[6]  = '{2'd0, 2'd1, 4'b0110, 32'h0,        32'h0,        32'h1234,     32'h0,        32'h0,        1, 0, 0, 32'h12340000};
    vt[7]  = '{2'd3, 2'd0, 4'b0011, 32'h0,        32'h1,        32'h0,        32'h0,        32'h24,       1, 0, 0, 32'h00000010};
    vt[8]  = '{2'd1, 2'd0, 4'b0111, 32'h0,        32'h80000000, 32'h1F,       32'h0,        32'h0,        1, 0, 0, 32'h00000001};
    vt[9]  = '{2'd0, 2'd2, 4'b1000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h1,        32'h0,        1, 0, 0, 32'h00000000};
    vt[10] = '{2'd0, 2'd3, 4'b1100, 32'h100,      32'h0,        32'h0,        32'h0,        32'h1,        1, 0, 0, 32'h000000FF};
    vt[11] = '{2'd1, 2'd0, 4'b1111, 32'h0,        32'h7FFF0000, 32'h8,        32'h0,        32'h0,        1, 0, 0, 32'h007FFF00};

    // ---- reset: live instruction on the ID inputs must be ignored ----
    clrn = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    mem_fwd = 32'h0; wb_fwd = 32'h0;
    drive_id(vt[3], 1'b1, 1'b0, 5'd17);
    tick();
    check("reset ctrl", {ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem}, 5'b0);
    check("reset wn", ex_wn, 5'd0);
    check("reset result", ex_result, 32'd0);
    check("reset qb", ex_qb, 32'd0);
    drive_bubble();
    clrn = 1'b1;
    tick();
    check("post-reset ctrl", {ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem}, 5'b0);
    check("post-reset result", ex_result, 32'd0);

    // ---- table-driven ALU / operand-select vectors ----
    for (int i = 0; i < 12; i++) begin
      drive_id(vt[i], 1'b1, 1'b0, 5'(i + 1));
      mem_fwd = vt[i].mfwd;
      wb_fwd  = vt[i].wfwd;
      tick();
      check($sformatf("v%0d result", i), ex_result, vt[i].exp);
      check($sformatf("v%0d ctrl", i), {ex_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem},
            {1'b0, 1'b1, vt[i].wreg, vt[i].m2reg, vt[i].wmem});
      check($sformatf("v%0d wn", i), ex_wn, 5'(i + 1));
      check($sformatf("v%0d qb", i), ex_qb, vt[i].qb);
    end

    // ---- invalid instruction: all write controls gated off ----
    nv = vt[3];
    nv.wmem = 1'b1;
    drive_id(nv, 1'b0, 1'b0, 5'd4);
    tick();
    check("invalid ctrl", {ex_valid, ex_wreg, ex_m2reg, ex_wmem}, 4'b0);

    // ---- mem_stall holds EX for 3 cycles, next instruction waits ----
    drive_id(vt[0], 1'b1, 1'b0, 5'd21);
    mem_fwd = 32'h10; wb_fwd = 32'h0;
    tick();
    check("stall pre result", ex_result, 32'h15);
    mem_stall = 1'b1;
    drive_id(vt[2], 1'b1, 1'b0, 5'd22);
    #1;
    check("stall ex_stall", ex_stall, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall c%0d result", c), ex_result, 32'h15);
      check($sformatf("stall c%0d wn", c), ex_wn, 5'd21);
      check($sformatf("stall c%0d ctrl", c), {ex_valid, ex_wreg, ex_m2reg, ex_wmem}, 4'b1100);
    end
    mem_stall = 1'b0;
    #1;
    check("stall release ex_stall", ex_stall, 1'b0);
    tick();
    check("after stall result", ex_result, 32'hFFFFFFFE);
    check("after stall wn", ex_wn, 5'd22);
    check("after stall ctrl", {ex_valid, ex_wreg, ex_wmem}, 3'b101);

    // ---- flush beats mem_stall ----
    drive_id(vt[0], 1'b1, 1'b0, 5'd5);
    tick();
    check("pre-flush valid", ex_valid, 1'b1);
    flush = 1'b1; mem_stall = 1'b1;
    tick();
    flush = 1'b0; mem_stall = 1'b0;
    check("flush ctrl", {ex_valid, ex_wreg, ex_m2reg, ex_wmem}, 4'b0);
    check("flush wn", ex_wn, 5'd0);

`ifdef PIPE_EX_MUL_EN
    // ---- multiply 7 * 0xFFFFFFFF: 33 stall cycles, result in 34th ----
    mv = '{2'd2, 2'd0, 4'b0000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h7, 32'h0, 1, 0, 0, 32'h0};
    nv = '{2'd0, 2'd1, 4'b0000, 32'h3, 32'h0, 32'h4, 32'h0, 32'h0, 1, 0, 0, 32'h7};
    drive_id(mv, 1'b1, 1'b1, 5'd9);
    mem_fwd = 32'h7;
    tick();
    drive_id(nv, 1'b1, 1'b0, 5'd3);
    for (int c = 1; c <= 33; c++) begin
      check($sformatf("mul c%0d stall", c), ex_stall, 1'b1);
      check($sformatf("mul c%0d bubble", c), {ex_valid, ex_wreg, ex_wmem}, 3'b0);
      if (c >= 2) begin
        mem_fwd = $urandom;
        wb_fwd  = $urandom;
      end
      if (c < 33) tick();
    end
    tick();
    check("mul done result", ex_result, 32'hFFFFFFF9);
    check("mul done ctrl", {ex_stall, ex_valid, ex_wreg}, 3'b011);
    check("mul done wn", ex_wn, 5'd9);
    tick();
    check("mul next result", ex_result, 32'h7);
    check("mul next stall", ex_stall, 1'b0);

    // ---- flush in BUSY cycle 10 aborts the multiply ----
    drive_id(mv, 1'b1, 1'b1, 5'd9);
    mem_fwd = 32'h7;
    tick();
    drive_bubble();
    for (int c = 0; c < 10; c++) tick();
    check("mul busy10 stall", ex_stall, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("mul flush ctrl", {ex_stall, ex_valid, ex_wreg}, 3'b0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mul flush c%0d result", c), ex_result, 32'h0);
      check($sformatf("mul flush c%0d stall", c), ex_stall, 1'b0);
      tick();
    end

    // ---- reset during BUSY aborts with no result ----
    drive_id(mv, 1'b1, 1'b1, 5'd9);
    mem_fwd = 32'h7;
    tick();
    drive_bubble();
    for (int c = 0; c < 5; c++) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mul reset c%0d", c), {ex_stall, ex_valid, ex_wreg}, 3'b0);
      check($sformatf("mul reset c%0d result", c), ex_result, 32'h0);
      tick();
    end
`else
    // ---- without the multiplier id_mul is ignored and nothing stalls ----
    mv = vt[0];
    drive_id(mv, 1'b1, 1'b1, 5'd9);
    mem_fwd = 32'h10;
    tick();
    check("nomul stall", ex_stall, 1'b0);
    check("nomul ctrl", {ex_valid, ex_wreg}, 2'b11);
    check("nomul result", ex_result, 32'h15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
